aes_out_serializer: RTL and testbench

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

---
 rtl/aes_out_serializer_if.sv | 41 ++++
 rtl/aes_out_serializer.sv | 123 ++++++++++++
 tb/tb_aes_out_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_out_serializer_if.sv
// ============================================================================
// Module   : aes_out_serializer_if
// Brief    : Bundle of the AES result input and the 32-bit serial output bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_out_serializer_if;
  logic         AES_data_out_valid;
  logic [127:0] AES_data_out;
  logic         ser_ready;
  logic         ser_valid;
  logic [31:0]  ser_data;
  logic         ser_last;
  logic [1:0]   buf_count;
  logic         overflow;

  modport slave (
    input  AES_data_out_valid,
    input  AES_data_out,
    input  ser_ready,
    output ser_valid,
    output ser_data,
    output ser_last,
    output buf_count,
    output overflow
  );

  modport master (
    output AES_data_out_valid,
    output AES_data_out,
    output ser_ready,
    input  ser_valid,
    input  ser_data,
    input  ser_last,
    input  buf_count,
    input  overflow
  );
endinterface

`default_nettype wire

// File: rtl/aes_out_serializer.sv
// ============================================================================
// Module   : aes_out_serializer
// Brief    : Buffers up to two 128-bit AES results and streams them as 32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_out_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic          AES_clk,
  input  wire logic          AES_rst,
  aes_out_serializer_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t       r_state;
  logic         r_valid_d;
  logic [127:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic [1:0]   r_idx;
  logic         r_ovf;
  logic         r_ser_valid;
  logic         r_ser_last;
  logic [31:0]  r_ser_data;

  logic         w_cap;
  logic         w_hs;
  logic         w_pop;
  logic         w_full;
  logic         w_push;
  logic         w_drop;
  logic [1:0]   w_count_nx;
  logic         w_rptr_nx;
  logic [1:0]   w_idx_nx;
  logic [127:0] w_head_nx;
  logic         w_send_nx;

  // Word select: MSB-first maps word idx to slot (3 - idx) counted from bit 0.
  function automatic logic [31:0] f_word(input logic [127:0] blk, input logic [1:0] idx);
    logic [1:0] slot;
    logic [6:0] lsb;
    slot = MSB_FIRST ? ~idx : idx;
    lsb  = {slot, 5'b0_0000};
    return blk[lsb +: 32];
  endfunction

  assign w_cap     = bus.AES_data_out_valid && !r_valid_d;
  assign w_hs      = (r_state == S_SEND) && bus.ser_ready;
  assign w_pop     = w_hs && (r_idx == 2'd3);
  assign w_full    = (r_count == 2'd2);
  assign w_push    = w_cap && (!w_full || w_pop);
  assign w_drop    = w_cap && w_full && !w_pop;
  assign w_rptr_nx = r_rptr ^ w_pop;
  assign w_idx_nx  = w_pop ? 2'd0 : (w_hs ? r_idx + 2'd1 : r_idx);

  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + 2'd1;
      2'b01:   w_count_nx = r_count - 2'd1;
      default: w_count_nx = r_count;
    endcase
  end

  // The next head may be the block being written this very cycle.
  assign w_head_nx = (w_push && (r_wptr == w_rptr_nx)) ? bus.AES_data_out : r_mem[w_rptr_nx];
  assign w_send_nx = (w_count_nx != 2'd0);

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      r_state     <= S_IDLE;
      r_valid_d   <= 1'b0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_idx       <= 2'd0;
      r_ovf       <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
      r_ser_data  <= 32'd0;
    end else begin
      r_valid_d <= bus.AES_data_out_valid;
      if (w_push) begin
        r_mem[r_wptr] <= bus.AES_data_out;
        r_wptr        <= ~r_wptr;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      r_rptr  <= w_rptr_nx;
      r_count <= w_count_nx;
      r_idx   <= w_idx_nx;

      case (r_state)
        S_IDLE:  r_state <= w_send_nx ? S_SEND : S_IDLE;
        S_SEND:  r_state <= w_send_nx ? S_SEND : S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      r_ser_valid <= w_send_nx;
      r_ser_last  <= w_send_nx && (w_idx_nx == 2'd3);
      r_ser_data  <= w_send_nx ? f_word(w_head_nx, w_idx_nx) : 32'd0;
    end
  end

  assign bus.ser_valid = r_ser_valid;
  assign bus.ser_data  = r_ser_data;
  assign bus.ser_last  = r_ser_last;
  assign bus.buf_count = r_count;
  assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_aes_out_serializer.sv
// ============================================================================
// Module   : tb_aes_out_serializer
// Brief    : Directed bench for aes_out_serializer with a word-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_out_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_out_serializer_if bus();

  aes_out_serializer #(.MSB_FIRST(1'b1)) dut (
    .AES_clk (clk),
    .AES_rst (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wd(input logic [127:0] b, input int k);
    logic [127:0] t;
    t = b >> (32 * (3 - k));
    return t[31:0];
  endfunction

  localparam logic [127:0] BLK_A  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] BLK_B  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK_C1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_C2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] BLK_C3 = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;

  // Reference model: the pending output as a flat stream of 32-bit words.
  logic [31:0] mq[$];
  bit          m_prev;
  bit          m_ovf;
  bit          m_started = 1'b0;
  bit          m_cap;
  bit          m_hs;
  bit          m_popb;
  int          m_blocks;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_prev    = 1'b0;
      m_ovf     = 1'b0;
      m_started = 1'b1;
    end else begin
      m_cap    = bus.AES_data_out_valid && !m_prev;
      m_prev   = bus.AES_data_out_valid;
      m_blocks = (mq.size() + 3) / 4;
      m_hs     = (mq.size() > 0) && bus.ser_ready;
      m_popb   = m_hs && (mq.size() % 4 == 1);
      if (m_hs) void'(mq.pop_front());
      if (m_cap) begin
        if (m_blocks < 2 || m_popb) begin
          for (int k = 0; k < 4; k++) mq.push_back(wd(bus.AES_data_out, k));
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_valid", 32'(bus.ser_valid), 32'(mq.size() > 0));
      chk("model_buf_count", 32'(bus.buf_count), 32'((mq.size() + 3) / 4));
      chk("model_overflow", 32'(bus.overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        chk("model_data", bus.ser_data, mq[0]);
        chk("model_last", 32'(bus.ser_last), 32'(mq.size() % 4 == 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [127:0] c_blk [3];
  logic [31:0]  exp8  [8];
  int           peak;
  int           cnt;

  initial begin
    bus.AES_data_out_valid = 1'b0;
    bus.AES_data_out       = '0;
    bus.ser_ready          = 1'b0;
    rst                    = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(bus.ser_valid), 32'd0);
    chk("rst_data", bus.ser_data, 32'd0);
    chk("rst_last", 32'(bus.ser_last), 32'd0);
    chk("rst_buf_count", 32'(bus.buf_count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst           = 1'b0;
    bus.ser_ready = 1'b1;

    // Single block, always ready
    bus.AES_data_out       = BLK_A;
    bus.AES_data_out_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.AES_data_out_valid = 1'b0;
      chk("t1_valid", 32'(bus.ser_valid), 32'd1);
      chk("t1_word", bus.ser_data, (k == 0) ? 32'h3925841d : (k == 1) ? 32'h02dc09fb :
                                   (k == 2) ? 32'hdc118597 : 32'h196a0b32);
      chk("t1_last", 32'(bus.ser_last), 32'(k == 3));
    end
    @(negedge clk);
    chk("t1_idle", 32'(bus.ser_valid), 32'd0);
    chk("t1_buf_count", 32'(bus.buf_count), 32'd0);

    // Back-pressure during word 1
    bus.AES_data_out_valid = 1'b1;
    @(negedge clk);
    bus.AES_data_out_valid = 1'b0;
    chk("t2_word0", bus.ser_data, 32'h3925841d);
    @(negedge clk);
    chk("t2_word1", bus.ser_data, 32'h02dc09fb);
    bus.ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold", bus.ser_data, 32'h02dc09fb);
      chk("t2_hold_valid", 32'(bus.ser_valid), 32'd1);
    end
    bus.ser_ready = 1'b1;
    @(negedge clk);
    chk("t2_word2", bus.ser_data, 32'hdc118597);
    @(negedge clk);
    chk("t2_word3", bus.ser_data, 32'h196a0b32);
    chk("t2_last", 32'(bus.ser_last), 32'd1);
    @(negedge clk);
    chk("t2_idle", 32'(bus.ser_valid), 32'd0);

    // Two blocks two cycles apart, no gap
    for (int k = 0; k < 4; k++) begin
      exp8[k]     = wd(BLK_A, k);
      exp8[k + 4] = wd(BLK_B, k);
    end
    peak = 0;
    bus.AES_data_out       = BLK_A;
    bus.AES_data_out_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_valid", 32'(bus.ser_valid), 32'd1);
      chk("t3_word", bus.ser_data, exp8[i]);
      if (int'(bus.buf_count) > peak) peak = int'(bus.buf_count);
      if (i == 0) bus.AES_data_out_valid = 1'b0;
      if (i == 1) begin
        bus.AES_data_out       = BLK_B;
        bus.AES_data_out_valid = 1'b1;
      end
      if (i == 2) bus.AES_data_out_valid = 1'b0;
    end
    chk("t3_peak", 32'(peak), 32'd2);
    @(negedge clk);
    chk("t3_idle", 32'(bus.ser_valid), 32'd0);

    // Overflow: three captures with no drain
    c_blk[0] = BLK_C1;
    c_blk[1] = BLK_C2;
    c_blk[2] = BLK_C3;
    bus.ser_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.AES_data_out       = c_blk[j];
      bus.AES_data_out_valid = 1'b1;
      @(negedge clk);
      bus.AES_data_out_valid = 1'b0;
      @(negedge clk);
    end
    chk("t4_buf_count", 32'(bus.buf_count), 32'd2);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    bus.ser_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_word", bus.ser_data, (i < 4) ? wd(BLK_C1, i) : wd(BLK_C2, i - 4));
      @(negedge clk);
    end
    chk("t4_idle", 32'(bus.ser_valid), 32'd0);
    chk("t4_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Valid held high for five cycles is a single capture
    cnt = 0;
    bus.AES_data_out       = BLK_B;
    bus.AES_data_out_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.ser_valid && bus.ser_ready) cnt++;
      if (i == 4) bus.AES_data_out_valid = 1'b0;
    end
    chk("t5_word_count", 32'(cnt), 32'd4);

    // Reset mid-block, with a capture request during reset
    bus.AES_data_out       = BLK_A;
    bus.AES_data_out_valid = 1'b1;
    @(negedge clk);
    bus.AES_data_out_valid = 1'b0;
    @(negedge clk);
    chk("t6_word1", bus.ser_data, 32'h02dc09fb);
    @(negedge clk);
    chk("t6_word2", bus.ser_data, 32'hdc118597);
    rst                    = 1'b1;
    bus.AES_data_out       = BLK_C1;
    bus.AES_data_out_valid = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 32'(bus.ser_valid), 32'd0);
    chk("t6_rst_buf_count", 32'(bus.buf_count), 32'd0);
    chk("t6_rst_overflow", 32'(bus.overflow), 32'd0);
    rst              = 1'b0;
    bus.AES_data_out = BLK_B;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.AES_data_out_valid = 1'b0;
      chk("t6_new_word", bus.ser_data, wd(BLK_B, k));
    end
    chk("t6_new_b0_literal", exp8[4], 32'h00112233);
    @(negedge clk);
    chk("t6_idle", 32'(bus.ser_valid), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
